// File: rtl/tt_bus_bridge.sv
// Core-to-TinyTapeout pin bridge: serialises address/data into byte beats
// on the bidirectional pads, free-running or with a 4-phase strobe/ack.
module tt_bus_bridge #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int HANDSHAKE = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ready,
   output logic              core_err,
   output logic [DATA_W-1:0] core_rdata,
   input  logic [7:0]        pin_in,
   output logic [7:0]        pin_out,
   input  logic [7:0]        pio_in,
   output logic [7:0]        pio_out,
   output logic [7:0]        pio_oe
);

   localparam int NA = (ADDR_W + 7) / 8;
   localparam int ND = (DATA_W + 7) / 8;
   localparam int AP = NA * 8;
   localparam int DP = ND * 8;

   localparam logic [1:0] PH_ADDR  = 2'b01;
   localparam logic [1:0] PH_WDATA = 2'b10;
   localparam logic [1:0] PH_RDATA = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_RDATA,
      S_ACKLOW,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    ph_q, ph_d;
   logic [1:0]    idx_q, idx_d;
   logic          we_q, we_d;
   logic [AP-1:0] addr_q, addr_d;
   logic [DP-1:0] wdata_q, wdata_d;
   logic [DP-1:0] rbuf_q, rbuf_d;
   logic          err_q, err_d;
   logic [7:0]    cnt_q, cnt_d;

   logic          ext_ack;
   logic          pin_unused;
   logic          last_beat;
   logic          tmo_hit;
   logic [DP-1:0] rd_merge;
   logic [7:0]    addr_byte;
   logic [7:0]    wdata_byte;
   state_t        seq_state;
   logic [1:0]    seq_ph;
   logic [1:0]    seq_idx;
   logic          active;
   logic          strobe;
   logic          drive;

   assign ext_ack    = pin_in[7];
   assign pin_unused = ^pin_in[6:0];

   assign last_beat = (ph_q == PH_ADDR) ? (idx_q == 2'(NA - 1))
                                        : (idx_q == 2'(ND - 1));

   assign tmo_hit = (TIMEOUT != 0) &&
                    (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT));

   always_comb begin
      addr_byte  = '0;
      wdata_byte = '0;
      rd_merge   = rbuf_q;
      for (int i = 0; i < NA; i++)
         if (idx_q == 2'(i)) addr_byte = addr_q[i*8 +: 8];
      for (int i = 0; i < ND; i++) begin
         if (idx_q == 2'(i)) begin
            wdata_byte        = wdata_q[i*8 +: 8];
            rd_merge[i*8 +: 8] = pio_in;
         end
      end
   end

   // Where a completed beat leads: next byte, next phase, or DONE.
   always_comb begin
      seq_ph  = ph_q;
      seq_idx = idx_q + 2'd1;
      unique case (1'b1)
         ph_q == PH_ADDR:  seq_state = S_ADDR;
         ph_q == PH_WDATA: seq_state = S_WDATA;
         default:          seq_state = S_RDATA;
      endcase
      if (last_beat) begin
         seq_idx = 2'd0;
         if (ph_q == PH_ADDR) begin
            seq_ph    = we_q ? PH_WDATA : PH_RDATA;
            seq_state = we_q ? S_WDATA : S_RDATA;
         end else begin
            seq_state = S_DONE;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      idx_d   = idx_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (core_req) begin
               state_d = S_ADDR;
               ph_d    = PH_ADDR;
               idx_d   = 2'd0;
               we_d    = core_we;
               addr_d  = AP'(core_addr);
               wdata_d = DP'(core_wdata);
               rbuf_d  = '0;
               err_d   = 1'b0;
               cnt_d   = 8'd0;
            end
         end
         S_ADDR, S_WDATA, S_RDATA: begin
            if (HANDSHAKE == 0 || ext_ack) begin
               if (state_q == S_RDATA) rbuf_d = rd_merge;
               cnt_d = 8'd0;
               if (HANDSHAKE == 0) begin
                  state_d = seq_state;
                  ph_d    = seq_ph;
                  idx_d   = seq_idx;
               end else begin
                  state_d = S_ACKLOW;
               end
            end else if (tmo_hit) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_ACKLOW: begin
            if (!ext_ack) begin
               state_d = seq_state;
               ph_d    = seq_ph;
               idx_d   = seq_idx;
               cnt_d   = 8'd0;
            end else if (tmo_hit) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ph_q    <= 2'd0;
         idx_q   <= 2'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // ACKLOW keeps the beat on the pads with strobe dropped.
   assign active = (state_q == S_ADDR) || (state_q == S_WDATA) ||
                   (state_q == S_RDATA) || (state_q == S_ACKLOW);
   assign strobe = (state_q == S_ADDR) || (state_q == S_WDATA) ||
                   (state_q == S_RDATA);
   assign drive  = active && (ph_q != PH_RDATA);

   assign pio_oe  = drive ? 8'hFF : 8'h00;
   assign pio_out = !drive ? 8'h00 :
                    (ph_q == PH_ADDR) ? addr_byte : wdata_byte;
   assign pin_out = active ? {1'b1, 1'b0, idx_q, ph_q, we_q, strobe}
                           : 8'h00;

   assign core_ready = (state_q == S_DONE);
   assign core_err   = (state_q == S_DONE) && err_q;
   assign core_rdata = rbuf_q[DATA_W-1:0];

endmodule

// File: tb/tb_tt_bus_bridge.sv
// Randomised bench for tt_bus_bridge: free-running, handshake/timeout
// and wide-address instances checked against a byte-beat reference model.
module tb_tt_bus_bridge;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       req;
   logic [2:0]       we;
   logic [2:0][31:0] addr;
   logic [2:0][31:0] wdata;
   logic [2:0][7:0]  pin_in;
   logic [2:0][7:0]  pio_in;
   logic [2:0]       rdy;
   logic [2:0]       err;
   logic [2:0][7:0]  pin_out;
   logic [2:0][7:0]  pio_out;
   logic [2:0][7:0]  pio_oe;
   logic [15:0]      rd0;
   logic [15:0]      rd1;
   logic [7:0]       rd2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tt_bus_bridge #(.ADDR_W(16), .DATA_W(16), .HANDSHAKE(0), .TIMEOUT(255)) u_fr (
      .clk(clk), .rst(rst), .core_req(req[0]), .core_we(we[0]),
      .core_addr(addr[0][15:0]), .core_wdata(wdata[0][15:0]),
      .core_ready(rdy[0]), .core_err(err[0]), .core_rdata(rd0),
      .pin_in(pin_in[0]), .pin_out(pin_out[0]),
      .pio_in(pio_in[0]), .pio_out(pio_out[0]), .pio_oe(pio_oe[0])
   );

   tt_bus_bridge #(.ADDR_W(16), .DATA_W(16), .HANDSHAKE(1), .TIMEOUT(10)) u_hs (
      .clk(clk), .rst(rst), .core_req(req[1]), .core_we(we[1]),
      .core_addr(addr[1][15:0]), .core_wdata(wdata[1][15:0]),
      .core_ready(rdy[1]), .core_err(err[1]), .core_rdata(rd1),
      .pin_in(pin_in[1]), .pin_out(pin_out[1]),
      .pio_in(pio_in[1]), .pio_out(pio_out[1]), .pio_oe(pio_oe[1])
   );

   tt_bus_bridge #(.ADDR_W(24), .DATA_W(8), .HANDSHAKE(0), .TIMEOUT(255)) u_wa (
      .clk(clk), .rst(rst), .core_req(req[2]), .core_we(we[2]),
      .core_addr(addr[2][23:0]), .core_wdata(wdata[2][7:0]),
      .core_ready(rdy[2]), .core_err(err[2]), .core_rdata(rd2),
      .pin_in(pin_in[2]), .pin_out(pin_out[2]),
      .pio_in(pio_in[2]), .pio_out(pio_out[2]), .pio_oe(pio_oe[2])
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rdata_of(int s);
      case (s)
         0:       return 32'(rd0);
         1:       return 32'(rd1);
         default: return 32'(rd2);
      endcase
   endfunction

   function automatic logic [7:0] byte_of(logic [31:0] v, int i);
      return 8'(v >> (8 * i));
   endfunction

   function automatic logic [31:0] mask_w(logic [31:0] v, int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return 32'(64'(v) & m);
   endfunction

   function automatic logic [7:0] ctl(int bi, int ph, logic w, logic stb);
      return {1'b1, 1'b0, 2'(bi), 2'(ph), w, stb};
   endfunction

   // Free-running: one beat per cycle, ready NA+ND+1 cycles after accept.
   task automatic run_free(int s, int na, int nd, int aw, int dw, logic w,
                           logic [31:0] a, logic [31:0] d, logic [31:0] rbytes);
      logic [31:0] am, dm, exp_rd;
      logic [7:0]  rb;
      int          bi, ph;
      logic        ad;
      am     = mask_w(a, aw);
      dm     = mask_w(d, dw);
      exp_rd = 0;
      @(negedge clk);
      req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
      for (int k = 0; k < na + nd; k++) begin
         @(negedge clk);
         req[s]   = (k < na + nd - 1) ? 1'($urandom) : 1'b0;
         we[s]    = 1'($urandom);
         addr[s]  = $urandom;
         wdata[s] = $urandom;
         ad = (k < na);
         bi = ad ? k : k - na;
         ph = ad ? 1 : (w ? 2 : 3);
         check("fr_ctl", pin_out[s], ctl(bi, ph, w, 1'b1));
         check("fr_rdy", rdy[s], 0);
         if (ph == 3) begin
            check("fr_oe_rd", pio_oe[s], 8'h00);
            rb = byte_of(rbytes, bi);
            pio_in[s] = rb;
            exp_rd |= 32'(rb) << (8 * bi);
         end else begin
            check("fr_oe_wr", pio_oe[s], 8'hFF);
            check("fr_byte", pio_out[s], ad ? byte_of(am, bi) : byte_of(dm, bi));
         end
      end
      @(negedge clk);
      pio_in[s] = $urandom;
      check("fr_ready", rdy[s], 1);
      check("fr_err", err[s], 0);
      check("fr_rdata", rdata_of(s), mask_w(exp_rd, dw));
      check("fr_done_oe", pio_oe[s], 8'h00);
      check("fr_done_busy", {pin_out[s][7], pin_out[s][0]}, 0);
      @(negedge clk);
      check("fr_ready_pulse", rdy[s], 0);
      check("fr_rdata_hold", rdata_of(s), mask_w(exp_rd, dw));
   endtask

   // Handshake instance: ack raised ad_ly cycles after strobe, dropped dr later.
   task automatic run_hs(logic w, logic [31:0] a, logic [31:0] d,
                         logic [31:0] rbytes, int ad_ly, int dr);
      logic [31:0] exp_rd;
      logic [7:0]  exp_po, exp_oe, exp_dat, rb;
      int          bi, ph, t;
      logic        ad;
      exp_rd = 0;
      @(negedge clk);
      req[1] = 1'b1; we[1] = w; addr[1] = a; wdata[1] = d;
      @(negedge clk);
      req[1] = 1'b0; we[1] = ~w; addr[1] = $urandom; wdata[1] = $urandom;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (pin_out[1][0] !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
         end
         check("hs_strobe_up", pin_out[1][0], 1);
         ad      = (k < 2);
         bi      = ad ? k : k - 2;
         ph      = ad ? 1 : (w ? 2 : 3);
         exp_po  = ctl(bi, ph, w, 1'b1);
         exp_oe  = (ph == 3) ? 8'h00 : 8'hFF;
         exp_dat = ad ? byte_of(a, bi) : byte_of(d, bi);
         check("hs_ctl", pin_out[1], exp_po);
         check("hs_oe", pio_oe[1], exp_oe);
         check("hs_rdy", rdy[1], 0);
         if (ph != 3) check("hs_byte", pio_out[1], exp_dat);
         if (ph == 3) begin
            rb = byte_of(rbytes, bi);
            pio_in[1] = rb;
            exp_rd |= 32'(rb) << (8 * bi);
         end
         for (int i = 1; i <= ad_ly; i++) begin
            @(negedge clk);
            check("hs_hold", pin_out[1], exp_po);
         end
         pin_in[1][7] = 1'b1;
         for (int j = 1; j <= dr; j++) begin
            @(negedge clk);
            if (j == 1) pio_in[1] = $urandom;
            check("hs_acklow_ctl", pin_out[1], exp_po & 8'hFE);
            check("hs_acklow_oe", pio_oe[1], exp_oe);
            if (ph != 3) check("hs_acklow_byte", pio_out[1], exp_dat);
         end
         pin_in[1][7] = 1'b0;
         @(negedge clk);
      end
      check("hs_ready", rdy[1], 1);
      check("hs_err", err[1], 0);
      check("hs_rdata", rdata_of(1), exp_rd);
      @(negedge clk);
      check("hs_ready_pulse", rdy[1], 0);
   endtask

   task automatic run_timeout(logic [31:0] a);
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = a;
      @(negedge clk);
      req[1] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         check("to_ctl", pin_out[1], ctl(0, 1, 1'b0, 1'b1));
         check("to_rdy", rdy[1], 0);
         @(negedge clk);
      end
      check("to_ready", rdy[1], 1);
      check("to_err", err[1], 1);
      check("to_rdata", rdata_of(1), 0);
      check("to_oe", pio_oe[1], 8'h00);
      @(negedge clk);
      check("to_ready_pulse", rdy[1], 0);
   endtask

   task automatic run_reset_mid;
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = $urandom; wdata[0] = $urandom;
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_phase", pin_out[0][3:2], 2'b10);
      rst = 1'b1;
      #1;
      check("rst_pin_out", pin_out[0], 0);
      check("rst_pio_out", pio_out[0], 0);
      check("rst_pio_oe", pio_oe[0], 0);
      check("rst_ready", rdy[0], 0);
      check("rst_err", err[0], 0);
      check("rst_rdata", rdata_of(0), 0);
      @(negedge clk);
      check("rst_ready_hold", rdy[0], 0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_after_rdy", rdy[0], 0);
         check("rst_after_ctl", pin_out[0], 0);
      end
   endtask

   // Wide address: req held through DONE restarts one cycle after DONE.
   task automatic run_back_to_back;
      logic [31:0] a1, a2, d1, d2;
      logic [7:0]  exp_b[4];
      a1 = $urandom; a2 = $urandom; d1 = $urandom; d2 = $urandom;
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = a1; wdata[2] = d1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) begin
            addr[2] = a2; wdata[2] = d2;
            check("bb_first_byte", pio_out[2], byte_of(a1, 0));
         end
         if (c < 5) check("bb_rdy", rdy[2], 0);
      end
      check("bb_ready1", rdy[2], 1);
      @(negedge clk);
      check("bb_idle_busy", pin_out[2][7], 0);
      check("bb_idle_rdy", rdy[2], 0);
      exp_b[0] = byte_of(a2, 0);
      exp_b[1] = byte_of(a2, 1);
      exp_b[2] = byte_of(a2, 2);
      exp_b[3] = byte_of(d2, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req[2] = 1'b0;
         check("bb_ctl", pin_out[2], (k < 3) ? ctl(k, 1, 1'b1, 1'b1)
                                             : ctl(0, 2, 1'b1, 1'b1));
         check("bb_byte", pio_out[2], exp_b[k]);
      end
      @(negedge clk);
      check("bb_ready2", rdy[2], 1);
      @(negedge clk);
      check("bb_ready2_pulse", rdy[2], 0);
   endtask

   initial begin
      rst = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0; pin_in = '0; pio_in = '0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check("reset_pin_out", pin_out[s], 0);
         check("reset_pio_oe", pio_oe[s], 0);
         check("reset_pio_out", pio_out[s], 0);
         check("reset_ready", rdy[s], 0);
         check("reset_rdata", rdata_of(s), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      run_free(0, 2, 2, 16, 16, 1'b1, 32'h1234, 32'hBEEF, 0);
      run_free(0, 2, 2, 16, 16, 1'b0, 32'h00A5, 0, 32'h2211);
      for (int n = 0; n < 8; n++)
         run_free(0, 2, 2, 16, 16, 1'($urandom), $urandom, $urandom, $urandom);

      run_hs(1'b1, 32'h1234, 32'hBEEF, 0, 3, 2);
      for (int n = 0; n < 5; n++)
         run_hs(1'($urandom), 32'($urandom_range(0, 16'hFFFF)),
                32'($urandom_range(0, 16'hFFFF)), $urandom,
                $urandom_range(1, 5), $urandom_range(1, 3));
      run_hs(1'b0, 32'h5A5A, 0, 32'h0000_C33C, 2, 1);
      run_timeout(32'($urandom_range(0, 16'hFFFF)));

      run_reset_mid();
      run_free(0, 2, 2, 16, 16, 1'b0, $urandom, $urandom, $urandom);

      for (int n = 0; n < 4; n++)
         run_free(2, 3, 1, 24, 8, 1'($urandom), $urandom, $urandom, $urandom);
      run_back_to_back();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
